// File: rtl/fetch_unit_pkg.sv
// Shared constants for the instruction-fetch front end.
package fetch_unit_pkg;

  localparam int              INSTR_W      = 32;
  localparam int              PC_INC       = 4;
  localparam int              XLEN_DEF     = 32;
  localparam logic [31:0]     RESET_PC_DEF = 32'h0000_0000;

endpackage

// File: rtl/fetch_unit_if.sv
// Bundles the imem request/response, redirect and decode-side handshakes of the fetch unit.
interface fetch_unit_if
  import fetch_unit_pkg::*;
#(
  parameter int XLEN = XLEN_DEF
);

  logic               imem_req_valid;
  logic               imem_req_ready;
  logic [XLEN-1:0]    imem_req_addr;
  logic               imem_rsp_valid;
  logic [INSTR_W-1:0] imem_rsp_data;
  logic               redirect_valid;
  logic [XLEN-1:0]    redirect_pc;
  logic               out_valid;
  logic               out_ready;
  logic [XLEN-1:0]    out_pc;
  logic [INSTR_W-1:0] out_instr;

  modport master (
    output imem_req_valid, imem_req_addr, out_valid, out_pc, out_instr,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data, redirect_valid, redirect_pc, out_ready
  );

  modport slave (
    input  imem_req_valid, imem_req_addr, out_valid, out_pc, out_instr,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data, redirect_valid, redirect_pc, out_ready
  );

endinterface

// File: rtl/fetch_unit_queue.sv
// First-word-fall-through synchronous FIFO with flush; holds {pc, instr} pairs for decode.
module fetch_queue #(
  parameter  int WIDTH = 64,
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  input  logic             flush_i,
  output logic [WIDTH-1:0] data_o,
  output logic             empty_o,
  output logic [CW-1:0]    count_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  // A push into a full queue is legal only when the head leaves in the same cycle.
  assign do_pop  = pop_i && (count_q != '0);
  assign do_push = push_i && ((count_q != CW'(DEPTH)) || do_pop);

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
      count_d = count_q + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push && !flush_i) mem_q[wr_ptr_q] <= data_i;
  end

  assign data_o  = mem_q[rd_ptr_q];
  assign empty_o = (count_q == '0);
  assign count_o = count_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch front end: credit-limited in-order imem requests, response queue to decode,
// and redirects that flush the queue and drop responses still in flight.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int              XLEN     = XLEN_DEF,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(RESET_PC_DEF),
  parameter int              FQ_DEPTH = 4
) (
  input  logic         clk,
  input  logic         reset,
  fetch_unit_if.master bus
);

  localparam int CW = $clog2(FQ_DEPTH) + 1;

  logic [XLEN-1:0]         fetch_pc_q, fetch_pc_d;
  logic [XLEN-1:0]         rsp_pc_q, rsp_pc_d;
  logic [CW-1:0]           outstanding_q, outstanding_d;
  logic [CW-1:0]           drop_cnt_q, drop_cnt_d;
  logic                    req_en_q;
  logic [CW-1:0]           fq_count;
  logic                    fq_empty;
  logic [CW:0]             credit_used;
  logic                    req_fire, rsp_eff, push, pop;
  logic [XLEN+INSTR_W-1:0] fq_wdata, fq_rdata;

  function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] pc);
    return {pc[XLEN-1:2], 2'b00};
  endfunction

  // req_en_q keeps the request channel quiet for the first cycle after a reset edge.
  assign credit_used        = {1'b0, outstanding_q} + {1'b0, fq_count};
  assign bus.imem_req_valid = reset && req_en_q && !bus.redirect_valid
                              && (credit_used < (CW+1)'(FQ_DEPTH));
  assign bus.imem_req_addr  = fetch_pc_q;

  assign req_fire = bus.imem_req_valid && bus.imem_req_ready;
  // A response with nothing outstanding is a protocol error and is ignored.
  assign rsp_eff  = bus.imem_rsp_valid && (outstanding_q != '0);
  assign push     = rsp_eff && (drop_cnt_q == '0) && !bus.redirect_valid;
  assign pop      = bus.out_valid && bus.out_ready;
  assign fq_wdata = {rsp_pc_q, bus.imem_rsp_data};

  always_comb begin
    fetch_pc_d    = fetch_pc_q;
    rsp_pc_d      = rsp_pc_q;
    drop_cnt_d    = drop_cnt_q;
    outstanding_d = outstanding_q + CW'(req_fire) - CW'(rsp_eff);
    if (bus.redirect_valid) begin
      // Everything still outstanding, minus a response consumed this cycle, is now stale.
      fetch_pc_d = word_align(bus.redirect_pc);
      rsp_pc_d   = word_align(bus.redirect_pc);
      drop_cnt_d = outstanding_q - CW'(rsp_eff);
    end else begin
      if (req_fire)                        fetch_pc_d = fetch_pc_q + XLEN'(PC_INC);
      if (push)                            rsp_pc_d   = rsp_pc_q + XLEN'(PC_INC);
      if (rsp_eff && (drop_cnt_q != '0))   drop_cnt_d = drop_cnt_q - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      fetch_pc_q    <= RESET_PC;
      rsp_pc_q      <= RESET_PC;
      outstanding_q <= '0;
      drop_cnt_q    <= '0;
      req_en_q      <= 1'b0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      rsp_pc_q      <= rsp_pc_d;
      outstanding_q <= outstanding_d;
      drop_cnt_q    <= drop_cnt_d;
      req_en_q      <= 1'b1;
    end
  end

  fetch_queue #(
    .WIDTH (XLEN + INSTR_W),
    .DEPTH (FQ_DEPTH)
  ) u_fetch_queue (
    .clk_i   (clk),
    .rst_ni  (reset),
    .push_i  (push),
    .data_i  (fq_wdata),
    .pop_i   (pop),
    .flush_i (bus.redirect_valid),
    .data_o  (fq_rdata),
    .empty_o (fq_empty),
    .count_o (fq_count)
  );

  assign bus.out_valid = !fq_empty;
  assign bus.out_pc    = fq_rdata[XLEN+INSTR_W-1:INSTR_W];
  assign bus.out_instr = fq_rdata[INSTR_W-1:0];

  rsp_without_request: assert property (@(posedge clk) disable iff (!reset)
    bus.imem_rsp_valid |-> (outstanding_q != '0));

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: in-order memory model plus a stream-level reference of expected PCs.
module tb_fetch_unit;
  import fetch_unit_pkg::*;

  localparam int          XLEN  = 32;
  localparam int          DEPTH = 4;
  localparam logic [31:0] RSTPC = 32'h0000_0000;
  localparam logic [31:0] KEY   = 32'hA5A5_0000;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  fetch_unit_if #(.XLEN(XLEN)) bus();

  fetch_unit #(.XLEN(XLEN), .RESET_PC(RSTPC), .FQ_DEPTH(DEPTH)) dut (
    .clk   (clk),
    .reset (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic [31:0] addr;
    int          due;
    bit          stale;
  } req_t;

  req_t        mem_q[$];
  int          cyc = 0;
  int          buffered = 0;
  logic [31:0] exp_out_pc = RSTPC;
  logic [31:0] exp_req_pc = RSTPC;
  bit          just_reset = 1'b0;
  bit          primed = 1'b0;
  int          lat_min = 1, lat_max = 1;
  int          n_checks = 0, n_fail = 0;

  bit          last_req_valid, last_out_valid, last_acc, last_pop;
  logic [31:0] last_acc_addr, last_pop_pc, last_pop_instr;

  // One clock cycle: drive memory response, compare against the stream model, advance the model.
  task automatic tick();
    bit   rsp, acc, pp, exp_rv, redir;
    int   lat;
    req_t e;
    logic [31:0] tgt;
    rsp = rst_n && (mem_q.size() > 0) && (mem_q[0].due <= cyc);
    bus.imem_rsp_valid = rsp;
    bus.imem_rsp_data  = rsp ? (mem_q[0].addr ^ KEY) : 32'h0;
    #1;
    redir = bus.redirect_valid;
    if (primed) begin
      exp_rv = rst_n && !just_reset && !redir && ((mem_q.size() + buffered) < DEPTH);
      n_checks++;
      if (bus.imem_req_valid !== exp_rv) begin
        n_fail++;
        $display("FAIL req_valid cyc=%0d got=%b exp=%b", cyc, bus.imem_req_valid, exp_rv);
      end
      if (exp_rv) begin
        n_checks++;
        if (bus.imem_req_addr !== exp_req_pc) begin
          n_fail++;
          $display("FAIL req_addr cyc=%0d got=%h exp=%h", cyc, bus.imem_req_addr, exp_req_pc);
        end
      end
      n_checks++;
      if (bus.out_valid !== (buffered > 0)) begin
        n_fail++;
        $display("FAIL out_valid cyc=%0d got=%b exp=%b", cyc, bus.out_valid, buffered > 0);
      end
      if (buffered > 0) begin
        n_checks++;
        if (bus.out_pc !== exp_out_pc || bus.out_instr !== (exp_out_pc ^ KEY)) begin
          n_fail++;
          $display("FAIL out_data cyc=%0d got pc=%h instr=%h exp pc=%h instr=%h", cyc,
                   bus.out_pc, bus.out_instr, exp_out_pc, exp_out_pc ^ KEY);
        end
      end
    end
    acc = (bus.imem_req_valid === 1'b1) && bus.imem_req_ready;
    pp  = (bus.out_valid === 1'b1) && bus.out_ready;
    last_req_valid = (bus.imem_req_valid === 1'b1);
    last_out_valid = (bus.out_valid === 1'b1);
    last_acc       = acc;
    last_pop       = pp;
    last_acc_addr  = bus.imem_req_addr;
    last_pop_pc    = bus.out_pc;
    last_pop_instr = bus.out_instr;
    tgt = {bus.redirect_pc[31:2], 2'b00};
    @(posedge clk);
    if (!rst_n) begin
      mem_q.delete();
      buffered   = 0;
      exp_out_pc = RSTPC;
      exp_req_pc = RSTPC;
      just_reset = 1'b1;
    end else begin
      just_reset = 1'b0;
      if (pp && buffered > 0) begin
        buffered--;
        exp_out_pc += 32'd4;
      end
      if (rsp) begin
        e = mem_q.pop_front();
        if (!e.stale && !redir) buffered++;
      end
      if (redir) begin
        buffered = 0;
        foreach (mem_q[i]) mem_q[i].stale = 1'b1;
        exp_out_pc = tgt;
        exp_req_pc = tgt;
      end
      if (acc) begin
        lat = $urandom_range(lat_max, lat_min);
        mem_q.push_back('{addr: last_acc_addr, due: cyc + lat, stale: redir});
        if (!redir) exp_req_pc += 32'd4;
      end
    end
    cyc++;
    primed = 1'b1;
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    bus.redirect_valid = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.imem_req_ready = 1'b1;
    bus.out_ready = 1'b0;
    lat_min = 1; lat_max = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (i > 0) begin
        n_checks++;
        if (last_req_valid || last_out_valid) begin
          n_fail++;
          $display("FAIL reset_quiet i=%0d got req=%b out=%b exp 0/0", i, last_req_valid, last_out_valid);
        end
      end
    end
    rst_n = 1'b1;
    tick();
    tick();
    n_checks++;
    if (!last_acc || last_acc_addr !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_first_req got acc=%b addr=%h exp 1/00000000", last_acc, last_acc_addr);
    end
    tick();
    n_checks++;
    if (last_out_valid) begin
      n_fail++;
      $display("FAIL reset_no_early_out got out_valid=1 exp 0");
    end
    bus.out_ready = 1'b1;
    tick();
    n_checks++;
    if (!last_pop || last_pop_pc !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_first_out got pop=%b pc=%h exp 1/00000000", last_pop, last_pop_pc);
    end
  endtask

  task automatic test_streaming();
    lat_min = 1; lat_max = 1;
    bus.imem_req_ready = 1'b1;
    bus.out_ready = 1'b1;
    do_reset();
    for (int i = 0; i < 25; i++) begin
      tick();
      if (i >= 3) begin
        n_checks++;
        if (!last_pop || last_pop_pc !== 32'(4 * (i - 3)) || last_pop_instr !== (32'(4 * (i - 3)) ^ KEY)) begin
          n_fail++;
          $display("FAIL stream i=%0d got pop=%b pc=%h instr=%h exp pc=%h", i, last_pop,
                   last_pop_pc, last_pop_instr, 32'(4 * (i - 3)));
        end
      end
    end
  endtask

  task automatic test_backpressure();
    int          accepts;
    logic [31:0] pops[$];
    logic [31:0] first_addr;
    bit          seen;
    lat_min = 1; lat_max = 1;
    bus.imem_req_ready = 1'b1;
    bus.out_ready = 1'b0;
    do_reset();
    accepts = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (last_acc) accepts++;
    end
    n_checks++;
    if (accepts != DEPTH || last_req_valid) begin
      n_fail++;
      $display("FAIL bp_credit got accepts=%0d req_valid=%b exp %0d/0", accepts, last_req_valid, DEPTH);
    end
    bus.out_ready = 1'b1;
    seen = 1'b0;
    first_addr = 32'hDEAD_BEEF;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (last_pop) pops.push_back(last_pop_pc);
      if (last_acc && !seen) begin
        seen = 1'b1;
        first_addr = last_acc_addr;
      end
    end
    for (int k = 0; k < 4; k++) begin
      n_checks++;
      if (pops.size() <= k || pops[k] !== 32'(4 * k)) begin
        n_fail++;
        $display("FAIL bp_drain k=%0d got=%h exp=%h", k, (pops.size() > k) ? pops[k] : 32'hX, 32'(4 * k));
      end
    end
    n_checks++;
    if (first_addr !== 32'h10) begin
      n_fail++;
      $display("FAIL bp_resume got=%h exp=00000010", first_addr);
    end
  endtask

  task automatic test_redirect_inflight();
    logic [31:0] pops[$];
    int          stale;
    lat_min = 3; lat_max = 3;
    bus.imem_req_ready = 1'b1;
    bus.out_ready = 1'b1;
    do_reset();
    repeat (3) tick();
    bus.redirect_valid = 1'b1;
    bus.redirect_pc = 32'h0000_0103;
    tick();
    bus.redirect_valid = 1'b0;
    n_checks++;
    if (last_req_valid) begin
      n_fail++;
      $display("FAIL redir_no_req got req_valid=1 exp 0");
    end
    stale = 0;
    for (int i = 0; i < 16; i++) begin
      tick();
      if (last_pop) begin
        pops.push_back(last_pop_pc);
        if (last_pop_pc < 32'h100) stale++;
      end
    end
    n_checks++;
    if (pops.size() < 2 || pops[0] !== 32'h100 || pops[1] !== 32'h104) begin
      n_fail++;
      $display("FAIL redir_seq got n=%0d first=%h second=%h exp 00000100 00000104", pops.size(),
               (pops.size() > 0) ? pops[0] : 32'hX, (pops.size() > 1) ? pops[1] : 32'hX);
    end
    n_checks++;
    if (stale != 0) begin
      n_fail++;
      $display("FAIL redir_stale got=%0d exp=0", stale);
    end
  endtask

  task automatic test_wrap();
    logic [31:0] pops[$];
    logic [31:0] want[3];
    want[0] = 32'hFFFF_FFF8;
    want[1] = 32'hFFFF_FFFC;
    want[2] = 32'h0000_0000;
    lat_min = 1; lat_max = 1;
    bus.out_ready = 1'b1;
    bus.redirect_valid = 1'b1;
    bus.redirect_pc = 32'hFFFF_FFF8;
    tick();
    bus.redirect_valid = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (last_pop) pops.push_back(last_pop_pc);
    end
    for (int k = 0; k < 3; k++) begin
      n_checks++;
      if (pops.size() <= k || pops[k] !== want[k]) begin
        n_fail++;
        $display("FAIL wrap k=%0d got=%h exp=%h", k, (pops.size() > k) ? pops[k] : 32'hX, want[k]);
      end
    end
  endtask

  task automatic test_reset_midstream();
    int accepts;
    int guard;
    lat_min = 1; lat_max = 1;
    bus.imem_req_ready = 1'b1;
    bus.out_ready = 1'b0;
    do_reset();
    guard = 0;
    while (buffered != 3 && guard < 20) begin
      tick();
      guard++;
    end
    n_checks++;
    if (buffered != 3) begin
      n_fail++;
      $display("FAIL mid_fill got buffered=%0d exp=3", buffered);
    end
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    n_checks++;
    if (last_out_valid || last_req_valid) begin
      n_fail++;
      $display("FAIL mid_cleared got out=%b req=%b exp 0/0", last_out_valid, last_req_valid);
    end
    tick();
    n_checks++;
    if (!last_acc || last_acc_addr !== RSTPC) begin
      n_fail++;
      $display("FAIL mid_restart got acc=%b addr=%h exp 1/%h", last_acc, last_acc_addr, RSTPC);
    end
    accepts = 1;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (last_acc) accepts++;
    end
    n_checks++;
    if (accepts != DEPTH) begin
      n_fail++;
      $display("FAIL mid_credit got accepts=%0d exp=%0d", accepts, DEPTH);
    end
  endtask

  task automatic test_random();
    int pops;
    pops = 0;
    lat_min = 1; lat_max = 3;
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      bus.imem_req_ready = ($urandom_range(3, 0) != 0);
      bus.out_ready      = ($urandom_range(9, 0) < 7);
      bus.redirect_valid = ($urandom_range(31, 0) == 0);
      bus.redirect_pc    = ($urandom_range(1, 0) == 0) ? $urandom : (32'hFFFF_FFF0 + $urandom_range(15, 0));
      rst_n              = ($urandom_range(399, 0) != 0);
      tick();
      if (last_pop) pops++;
    end
    rst_n = 1'b1;
    bus.redirect_valid = 1'b0;
    n_checks++;
    if (pops < 500) begin
      n_fail++;
      $display("FAIL random_progress got pops=%0d exp>=500", pops);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    bus.imem_req_ready = 1'b0;
    bus.imem_rsp_valid = 1'b0;
    bus.imem_rsp_data  = 32'h0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = 32'h0;
    bus.out_ready      = 1'b0;
    test_reset();
    test_streaming();
    test_backpressure();
    test_redirect_inflight();
    test_wrap();
    test_reset_midstream();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
